// File: rtl/counter_pkg.sv
// Shared constants for the parameterised up/down counter.
// Direction and mode encodings used by the top and the next-count logic.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count and boundary-event logic.
// Arithmetic is carried one bit wider than the count register.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 3,
  parameter longint unsigned MODULUS  = 8,
  parameter int              SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] next_count,
  output logic             boundary
);

  localparam longint unsigned MAXL = MODULUS - 1;
  localparam logic [WIDTH:0]  MAX  = MAXL[WIDTH:0];

  logic [WIDTH:0] cur;
  logic [WIDTH:0] lv;
  logic [WIDTH:0] nxt;
  logic           unused_msb;

  assign cur = {1'b0, count};
  assign lv  = {1'b0, load_val};

  always_comb begin
    nxt      = cur;
    boundary = 1'b0;
    priority case (1'b1)
      clear: nxt = '0;
      load:  nxt = (lv > MAX) ? MAX : lv;
      (en && up_dn == DIR_UP): begin
        if (cur == MAX) begin
          boundary = 1'b1;
          nxt      = (SATURATE == MODE_SAT) ? cur : '0;
        end else begin
          nxt = cur + 1'b1;
        end
      end
      (en && up_dn == DIR_DN): begin
        if (cur == '0) begin
          boundary = 1'b1;
          nxt      = (SATURATE == MODE_SAT) ? cur : MAX;
        end else begin
          nxt = cur - 1'b1;
        end
      end
      default: nxt = cur;
    endcase
  end

  assign next_count = nxt[WIDTH-1:0];
  // MSB is always zero once the result is bounded by MAX
  assign unused_msb = nxt[WIDTH];

endmodule

// File: rtl/up_down_counter_param.sv
// Parameterised up/down counter with wrap/saturate boundary handling.
// Holds the count/flag registers and the terminal-count decode.
module up_down_counter_param
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 3,
  parameter longint unsigned MODULUS  = 8,
  parameter int              SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             ovf,
  output logic             tc
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "up_down_counter_param: WIDTH out of range");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_mod
    $fatal(1, "up_down_counter_param: MODULUS out of range");
  end

  localparam longint unsigned MAXL = MODULUS - 1;
  localparam logic [WIDTH-1:0] TOP = MAXL[WIDTH-1:0];

  logic [WIDTH-1:0] next_count;
  logic             boundary;

  counter_next_calc #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .count      (count),
    .up_dn      (up_dn),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .clear      (clear),
    .next_count (next_count),
    .boundary   (boundary)
  );

  // boundary is never raised while clear or load wins the edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= next_count;
      wrap  <= boundary;
      ovf   <= clear ? 1'b0 : (ovf | boundary);
    end
  end

  assign tc = (up_dn == DIR_UP && count == TOP) ||
              (up_dn == DIR_DN && count == '0);

endmodule

// File: tb/tb_up_down_counter_param.sv
// Directed bench for up_down_counter_param in three configurations.
// A behavioural model per instance is checked on every falling edge.
module tb_up_down_counter_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       load = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] lv = 4'd0;

  logic [2:0] ca, cb;
  logic [3:0] cc;
  logic       wa, wb, wc, oa, ob, oc, ta, tb, tcc;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  up_down_counter_param #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(lv[2:0]), .clear(clear),
    .count(ca), .wrap(wa), .ovf(oa), .tc(ta));

  up_down_counter_param #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(lv[2:0]), .clear(clear),
    .count(cb), .wrap(wb), .ovf(ob), .tc(tb));

  up_down_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(lv), .clear(clear),
    .count(cc), .wrap(wc), .ovf(oc), .tc(tcc));

  task automatic check(string name, longint act, longint exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  int mc[3];
  int mw[3];
  int mo[3];
  int mm[3] = '{8, 6, 10};
  int ms[3] = '{0, 0, 1};

  function automatic void step(int i, int lvv);
    int m;
    m = mm[i];
    if (clear) begin
      mc[i] = 0; mw[i] = 0; mo[i] = 0;
    end else if (load) begin
      mc[i] = (lvv < m) ? lvv : m - 1;
      mw[i] = 0;
    end else if (en && up_dn) begin
      if (mc[i] == m - 1) begin
        mw[i] = 1; mo[i] = 1;
        if (ms[i] == 0) mc[i] = 0;
      end else begin
        mc[i] = mc[i] + 1; mw[i] = 0;
      end
    end else if (en) begin
      if (mc[i] == 0) begin
        mw[i] = 1; mo[i] = 1;
        if (ms[i] == 0) mc[i] = m - 1;
      end else begin
        mc[i] = mc[i] - 1; mw[i] = 0;
      end
    end else begin
      mw[i] = 0;
    end
  endfunction

  function automatic int mtc(int i);
    return up_dn ? int'(mc[i] == mm[i] - 1) : int'(mc[i] == 0);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        mc[i] = 0; mw[i] = 0; mo[i] = 0;
      end
    end else begin
      step(0, int'(lv) % 8);
      step(1, int'(lv) % 8);
      step(2, int'(lv));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("A.count", ca, mc[0]);
      check("A.wrap", wa, mw[0]);
      check("A.ovf", oa, mo[0]);
      check("A.tc", ta, mtc(0));
      check("B.count", cb, mc[1]);
      check("B.wrap", wb, mw[1]);
      check("B.ovf", ob, mo[1]);
      check("B.tc", tb, mtc(1));
      check("C.count", cc, mc[2]);
      check("C.wrap", wc, mw[2]);
      check("C.ovf", oc, mo[2]);
      check("C.tc", tcc, mtc(2));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("rst.A.count", ca, 0);
    check("rst.A.wrap", wa, 0);
    check("rst.A.ovf", oa, 0);
    check("rst.C.count", cc, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // wrap-around counting up through the full binary range
    en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("s1.count", ca, k % 8);
      check("s1.wrap", wa, (k == 8) ? 1 : 0);
    end
    check("s1.ovf", oa, 1);
    tick();
    check("s1.wrap_drop", wa, 0);
    check("s1.ovf_sticky", oa, 1);

    // asynchronous reset between edges
    for (int k = 0; k < 4; k++) tick();
    check("s5.pre.count", ca, 5);
    #2 rst = 1'b0;
    #1;
    check("s5.count", ca, 0);
    check("s5.ovf", oa, 0);
    check("s5.wrap", wa, 0);
    rst = 1'b1;

    // direction toggling
    en = 1'b0; load = 1'b1; lv = 4'd3;
    tick();
    check("s6.load", ca, 3);
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      up_dn = (k % 2 == 0);
      tick();
      check("s6.count", ca, (k % 2 == 0) ? 4 : 3);
      check("s6.tc", ta, 0);
      check("s6.wrap", wa, 0);
    end

    // clear beats load beats enable
    en = 1'b0; load = 1'b1; lv = 4'd7;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick();
    check("s4.wrap", wa, 1);
    check("s4.ovf_set", oa, 1);
    load = 1'b1; en = 1'b0; lv = 4'd4;
    tick();
    check("s4.load4", ca, 4);
    check("s4.ovf_kept", oa, 1);
    clear = 1'b1; load = 1'b1; en = 1'b1; lv = 4'd6;
    tick();
    check("s4.clear.count", ca, 0);
    check("s4.clear.ovf", oa, 0);
    clear = 1'b0; lv = 4'd2;
    tick();
    check("s4.load_over_en", ca, 2);

    // modulus 6 down-wrap and load clamping
    load = 1'b0; en = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick();
    check("s2.count", cb, 5);
    check("s2.wrap", wb, 1);
    en = 1'b0; load = 1'b1; lv = 4'd7;
    tick();
    check("s2.clamp", cb, 5);
    check("s2.A.load7", ca, 7);

    // saturating at the top
    lv = 4'd8;
    tick();
    check("s3.load", cc, 8);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("s3.count", cc, 9);
      check("s3.wrap", wc, (k == 0) ? 0 : 1);
      check("s3.tc", tcc, 1);
    end

    // saturating at the bottom
    en = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick();
    check("sat_dn.count", cc, 0);
    check("sat_dn.wrap", wc, 1);
    tick();
    check("sat_dn.hold", cc, 0);
    check("sat_dn.ovf", oc, 1);
    en = 1'b0;
    tick();
    check("sat_dn.wrap_drop", wc, 0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/up_down_counter_param.md
UP_DOWN_COUNTER_PARAM -- requirements
Module: up_down_counter_param

Interface
REQ-001 Parameter WIDTH, default 3: count register width in bits, legal range 1..32.
REQ-002 Parameter MODULUS, default 8: count range 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at the boundary, 1 = hold at the boundary.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low; synchronous deassert is the system's job.
REQ-006 en  input  1  count enable.
REQ-007 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-008 load  input  1  synchronous parallel load strobe.
REQ-009 load_val  input  WIDTH  value applied on load.
REQ-010 clear  input  1  synchronous clear to 0.
REQ-011 count  output  WIDTH  registered count value.
REQ-012 wrap  output  1  registered one-cycle pulse on a boundary event.
REQ-013 ovf  output  1  registered sticky flag for boundary events.
REQ-014 tc  output  1  combinational terminal-count indicator.

Function
REQ-015 Per-edge priority: clear > load > en; with none asserted, count holds.
REQ-016 clear: count <= 0, ovf <= 0, wrap <= 0.
REQ-017 load: count <= load_val if load_val < MODULUS, else count <= MODULUS-1.
REQ-018 load: wrap <= 0 and ovf unchanged.
REQ-019 en with up_dn=1 and count < MODULUS-1: count <= count+1, wrap <= 0.
REQ-020 en with up_dn=0 and count > 0: count <= count-1, wrap <= 0.
REQ-021 Up boundary (en, up_dn=1, count == MODULUS-1): SATURATE=0 gives count <= 0; SATURATE=1 gives count holds.
REQ-022 Up boundary, either mode: wrap <= 1 and ovf <= 1.
REQ-023 Down boundary (en, up_dn=0, count == 0): SATURATE=0 gives count <= MODULUS-1; SATURATE=1 gives count holds.
REQ-024 Down boundary, either mode: wrap <= 1 and ovf <= 1.
REQ-025 wrap is high for exactly the one cycle after a boundary event; back-to-back boundary events (saturate mode) keep it high.
REQ-026 tc = 1 when (up_dn=1 and count == MODULUS-1) or (up_dn=0 and count == 0), independent of en.
REQ-027 Direction change takes effect on the same edge as en; no pipeline stage and no latency beyond one clock.
REQ-028 Next-count arithmetic uses WIDTH+1 bits internally; no intermediate truncation when MODULUS == 2**WIDTH.
REQ-029 count never holds a value >= MODULUS after any edge.

Reset
REQ-030 rst low, asynchronously: count = 0, wrap = 0, ovf = 0, regardless of clk.
REQ-031 rst low mid-count overrides any concurrent clear, load or en.
REQ-032 The first edge after rst deasserts applies REQ-015 normally.

Structure
REQ-033 Shared package counter_pkg holds the direction constants (DIR_UP=1, DIR_DN=0) and the mode constants (MODE_WRAP=0, MODE_SAT=1).
REQ-034 One sub-module, counter_next_calc, is combinational: inputs count, up_dn, en, load, load_val, clear; outputs next count and a boundary flag.
REQ-035 The top level holds only registers, the tc decode and ovf/wrap flag logic.
REQ-036 Parameter legality is checked at elaboration: MODULUS > 2**WIDTH or MODULUS < 2 is a fatal error.

Verification
REQ-037 Each directed scenario below is run on a self-checking bench that compares against a reference model every cycle.
REQ-038 Scenario 1, WIDTH=3, MODULUS=8, SATURATE=0, up, en=1 for 9 cycles: count 0,1,..,7,0; wrap=1 only in the cycle count=0 reappears; ovf=1 thereafter.
REQ-039 Scenario 2, WIDTH=3, MODULUS=6, SATURATE=0, down from 0: next count=5, wrap=1; load_val=7 gives count=5 (clamped).
REQ-040 Scenario 3, WIDTH=4, MODULUS=10, SATURATE=1, up from 8 for 4 cycles: count 9,9,9,9; wrap high for the 3 cycles after reaching 9; tc=1 while count=9.
REQ-041 Scenario 4, simultaneous clear=1, load=1, en=1 at count=4: next count=0, ovf cleared; load=1 with en=1, load_val=2: next count=2.
REQ-042 Scenario 5, rst pulsed low between clock edges at count=5, ovf=1: count=0, ovf=0, wrap=0 immediately, before the next edge.
REQ-043 Scenario 6, up_dn toggled every cycle with en=1 from count=3: count 4,3,4,3; tc stays 0; wrap stays 0.
